// File: rtl/serial_addsub_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : serial_addsub_if
// Description : Request/response bundle for the serial add/subtract engine.
//               Requester drives start, mode, a, b and cin; the engine
//               returns busy, done, result, cout, ovf and zero.
//               Modports: master (requester side), slave (engine side).
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, result, cout, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : serial_addsub
// Description : Multi-cycle add/subtract unit. Consumes DIGIT bits of the
//               latched operands per clock, LSB slice first, and reports a
//               WIDTH-bit result with carry/borrow, signed overflow and zero.
//               WIDTH >= 2 and DIGIT must divide WIDTH.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               bus   - serial_addsub_if.slave (start/mode/a/b/cin in,
//                       busy/done/result/cout/ovf/zero out)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  serial_addsub_if.slave  bus
);

  localparam int                c_n     = WIDTH / DIGIT;
  localparam int                c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  // Operands are shifted right each slice so the active slice is always
  // at bit 0; the sign bits are kept separately for the overflow flag.
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_sa;
  logic                 r_sb;
  logic                 r_mode;
  logic                 r_carry;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_acc;

  logic [WIDTH-1:0]     r_result;
  logic                 r_cout;
  logic                 r_ovf;
  logic                 r_zero;

  logic                 w_accept;
  logic                 w_last;
  logic [DIGIT-1:0]     w_sum;
  logic                 w_cout;
  logic [WIDTH-1:0]     w_acc_next;
  logic [WIDTH-1:0]     w_a_next;
  logic [WIDTH-1:0]     w_b_next;
  logic                 w_sr;
  logic                 w_ovf;

  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_cnt == c_last);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- slice adder
  // Ripple through the DIGIT bits of the current slice. The borrow form
  // differs from the carry form only in the inverted minuend terms.
  always_comb begin : slice_calc
    logic c;
    logic x;
    c     = r_carry;
    x     = 1'b0;
    w_sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      x        = r_a[i] ^ r_b[i];
      w_sum[i] = x ^ c;
      if (r_mode) begin
        c = (~r_a[i] & r_b[i]) | (~x & c);
      end else begin
        c = (r_a[i] & r_b[i]) | (x & c);
      end
    end
    w_cout = c;
  end

  // New slice enters the accumulator at the top; after N slices the
  // first slice has reached bit 0.
  if (DIGIT == WIDTH) begin : g_single_slice
    assign w_acc_next = w_sum;
    assign w_a_next   = '0;
    assign w_b_next   = '0;
  end else begin : g_multi_slice
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:DIGIT]};
    assign w_a_next   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
    assign w_b_next   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
  end

  assign w_sr  = w_acc_next[WIDTH-1];
  assign w_ovf = r_mode ? ((r_sa != r_sb) && (w_sr != r_sa))
                        : ((r_sa == r_sb) && (w_sr != r_sa));

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_mode   <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_sa    <= bus.a[WIDTH-1];
      r_sb    <= bus.b[WIDTH-1];
      r_mode  <= bus.mode;
      r_carry <= bus.cin;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_carry <= w_cout;
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + 1'b1;
      // Visible outputs only move on the final slice so they stay stable
      // for the whole run.
      if (w_last) begin
        r_result <= w_acc_next;
        r_cout   <= w_cout;
        r_ovf    <= w_ovf;
        r_zero   <= (w_acc_next == '0);
      end
    end
  end

  assign bus.busy   = (r_state == S_RUN);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;
  assign bus.zero   = r_zero;

endmodule
`default_nettype wire
